// File: rtl/idct_bw31_pkg.sv
// Shared constants for the idct_bw31 8x8 inverse DCT.
// Cosine table, FSM codes, approximation width and Q formats.
package idct_bw31_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_ROW  = 3'd2,
        S_COL  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam int APX_BITS  = 6;
    localparam int Q_ROW     = 12;
    localparam int Q_OUT     = 17;
    localparam int COL_SHIFT = 2 * Q_ROW - Q_OUT;

    // KTAB[k][n] = round(2^12 * C(k)/2 * cos((2n+1)k*pi/16))
    localparam logic signed [12:0] KTAB [8][8] = '{
        '{ 13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,
           13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448 },
        '{ 13'sd2009,  13'sd1703,  13'sd1138,  13'sd400,
          -13'sd400,  -13'sd1138, -13'sd1703, -13'sd2009 },
        '{ 13'sd1892,  13'sd784,  -13'sd784,  -13'sd1892,
          -13'sd1892, -13'sd784,   13'sd784,   13'sd1892 },
        '{ 13'sd1703, -13'sd400,  -13'sd2009, -13'sd1138,
           13'sd1138,  13'sd2009,  13'sd400,  -13'sd1703 },
        '{ 13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,
           13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448 },
        '{ 13'sd1138, -13'sd2009,  13'sd400,   13'sd1703,
          -13'sd1703, -13'sd400,   13'sd2009, -13'sd1138 },
        '{ 13'sd784,  -13'sd1892,  13'sd1892, -13'sd784,
          -13'sd784,   13'sd1892, -13'sd1892,  13'sd784 },
        '{ 13'sd400,  -13'sd1138,  13'sd1703, -13'sd2009,
           13'sd2009, -13'sd1703,  13'sd1138, -13'sd400 }
    };

endpackage

// File: rtl/idct_bw31_dot8.sv
// 8-term signed dot product shared by the row and column passes.
// In approximate mode each product loses its low APX_BITS bits.
module idct_bw31_dot8 #(
    parameter int APX_BITS = 6
) (
    input  logic               apx,
    input  logic signed [31:0] a [8],
    input  logic signed [12:0] b [8],
    output logic signed [47:0] sum
);

    localparam logic [47:0] KEEP = ~((48'd1 << APX_BITS) - 48'd1);

    logic signed [47:0] ae;
    logic signed [47:0] be;
    logic signed [47:0] p;

    always_comb begin
        sum = '0;
        ae  = '0;
        be  = '0;
        p   = '0;
        for (int t = 0; t < 8; t++) begin
            ae = {{16{a[t][31]}}, a[t]};
            be = {{35{b[t][12]}}, b[t]};
            p  = ae * be;
            if (apx) begin
                p = p & KEEP;
            end
            sum = sum + p;
        end
    end

endmodule

// File: rtl/idct_bw31.sv
// 8x8 two-pass fixed-point inverse DCT with optional truncated products.
// Loads 64 coefficients, runs row and column passes, streams 64 pixels.
import idct_bw31_pkg::*;

module idct_bw31 #(
    parameter int BitWidth = 31,
    parameter int APX_BITS = idct_bw31_pkg::APX_BITS
) (
    input  logic              clk,
    input  logic              racc,
    input  logic              start,
    input  logic              rapx,
    input  logic [BitWidth:0] din,
    output logic              done,
    output logic [BitWidth:0] dout,
    output logic              reading,
    output logic [4:0]        state_out
);

    state_t state;
    logic [5:0] cnt;
    logic       apx;

    logic        [11:0]       ibuf [64];
    logic signed [31:0]       rbuf [64];
    logic        [BitWidth:0] obuf [64];

    logic signed [31:0] a [8];
    logic signed [12:0] b [8];
    logic signed [47:0] sum;
    logic signed [47:0] shifted;
    logic               unused;

    // Row pass: R(u,j) = sum_v F(u,v) K(v,j); column: x(i,j) = sum_u K(u,i) R(u,j)
    always_comb begin
        for (int t = 0; t < 8; t++) begin
            if (state == S_ROW) begin
                a[t] = {{20{ibuf[{cnt[5:3], t[2:0]}][11]}},
                        ibuf[{cnt[5:3], t[2:0]}]};
                b[t] = KTAB[t[2:0]][cnt[2:0]];
            end else begin
                a[t] = rbuf[{t[2:0], cnt[2:0]}];
                b[t] = KTAB[t[2:0]][cnt[5:3]];
            end
        end
    end

    idct_bw31_dot8 #(
        .APX_BITS (APX_BITS)
    ) u_dot8 (
        .apx (apx),
        .a   (a),
        .b   (b),
        .sum (sum)
    );

    assign shifted   = sum >>> COL_SHIFT;
    assign state_out = {2'b00, state};
    assign unused    = &{1'b0, din[BitWidth:12], shifted[47:BitWidth+1]};

    always_ff @(posedge clk) begin
        if ((state == S_IDLE && start) || state == S_READ) begin
            ibuf[cnt] <= din[11:0];
        end
        if (state == S_ROW) begin
            rbuf[cnt] <= sum[31:0];
        end
        if (state == S_COL) begin
            obuf[cnt] <= shifted[BitWidth:0];
        end
    end

    always_ff @(posedge clk or negedge racc) begin
        if (!racc) begin
            state   <= S_IDLE;
            cnt     <= '0;
            apx     <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
            reading <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    reading <= 1'b1;
                    if (start) begin
                        apx   <= rapx;
                        cnt   <= 6'd1;
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd63) begin
                        state   <= S_ROW;
                        reading <= 1'b0;
                    end
                end
                S_ROW: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd63) begin
                        state <= S_COL;
                    end
                end
                S_COL: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd63) begin
                        state <= S_OUT;
                        done  <= 1'b1;
                        dout  <= obuf[0];
                    end
                end
                S_OUT: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd63) begin
                        state   <= S_IDLE;
                        done    <= 1'b0;
                        reading <= 1'b1;
                    end else begin
                        dout <= obuf[cnt + 6'd1];
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idct_bw31.sv
// Scoreboard bench for idct_bw31 with an independent integer model.
module tb_idct_bw31;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        racc = 1'b0;
    logic        start = 1'b0;
    logic        rapx = 1'b0;
    logic [31:0] din = '0;
    logic        done;
    logic [31:0] dout;
    logic        reading;
    logic [4:0]  state_out;

    int ktab [8][8];
    int exp_q [$];
    int tests = 0;
    int fails = 0;

    idct_bw31 dut (
        .clk       (clk),
        .racc      (racc),
        .start     (start),
        .rapx      (rapx),
        .din       (din),
        .done      (done),
        .dout      (dout),
        .reading   (reading),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act,
                         input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic build_ktab();
        real ck;
        for (int k = 0; k < 8; k++) begin
            ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            for (int n = 0; n < 8; n++) begin
                ktab[k][n] = $rtoi($floor(4096.0 * ck / 2.0 *
                    $cos(real'((2 * n + 1) * k) * PI / 16.0) + 0.5));
            end
        end
    endtask

    task automatic model(input int f [64], input bit ap);
        int r [64];
        longint acc;
        longint p;
        for (int u = 0; u < 8; u++) begin
            for (int j = 0; j < 8; j++) begin
                acc = 0;
                for (int v = 0; v < 8; v++) begin
                    p = longint'(f[u * 8 + v]) * longint'(ktab[v][j]);
                    if (ap) p = p & ~longint'(63);
                    acc += p;
                end
                r[u * 8 + j] = int'(acc);
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                acc = 0;
                for (int u = 0; u < 8; u++) begin
                    p = longint'(r[u * 8 + j]) * longint'(ktab[u][i]);
                    if (ap) p = p & ~longint'(63);
                    acc += p;
                end
                exp_q.push_back(int'(acc >>> 7));
            end
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("dout", $signed(dout), exp_q.pop_front());
            end
        end
    end

    task automatic run_block(input int f [64], input bit ap,
                             input int abort_at, input bit inject);
        int junk;
        int es;
        bit seen;
        if (abort_at < 0) model(f, ap);
        for (int c = 0; c <= 256; c++) begin
            @(negedge clk);
            junk = $urandom();
            if (c < 64) begin
                start = (c == 0) || (c % 7 != 3);
                rapx  = (c == 0) ? ap : ~ap;
                din   = {junk[19:0], f[c][11:0]};
            end else begin
                start = inject && (c == 80 || c == 81);
                rapx  = 1'b0;
                din   = junk;
            end
            if (c == abort_at) begin
                racc = 1'b0;
                #1;
                check("abort_state", state_out, 0);
                check("abort_done", done, 0);
                check("abort_dout", dout, 0);
                check("abort_reading", reading, 0);
                break;
            end
            es = (c == 0) ? 0 : (c < 64) ? 1 : (c < 128) ? 2 :
                 (c < 192) ? 3 : (c < 256) ? 4 : 0;
            check("state", state_out, es);
            check("done_window", done, (c >= 192 && c < 256) ? 1 : 0);
            check("reading", reading, (c < 64 || c == 256) ? 1 : 0);
        end
        start = 1'b0;
        if (abort_at >= 0) begin
            @(negedge clk);
            racc = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            check("no_output_after_abort", seen, 0);
            check("idle_after_abort", state_out, 0);
        end
    endtask

    initial begin
        int f [64];
        build_ktab();

        repeat (2) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        check("rst_state", state_out, 0);
        check("rst_reading", reading, 0);
        racc = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_reading", reading, 1);
        check("rel_state", state_out, 0);

        foreach (f[n]) f[n] = 0;
        f[0] = 1024;
        run_block(f, 1'b0, -1, 1'b1);

        foreach (f[n]) f[n] = 0;
        run_block(f, 1'b0, -1, 1'b0);
        run_block(f, 1'b1, -1, 1'b0);

        f[1] = 100;
        run_block(f, 1'b0, -1, 1'b0);

        foreach (f[n]) f[n] = $urandom_range(0, 1024) - 512;
        run_block(f, 1'b0, -1, 1'b0);
        run_block(f, 1'b1, -1, 1'b0);

        f[0] = -2048;
        f[63] = 2047;
        run_block(f, 1'b1, 150, 1'b0);
        run_block(f, 1'b1, -1, 1'b1);

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
